// File: rtl/mem_pkg.sv
// Shared types, limits and parameter-legality helpers for the synchronous memory controller.
package mem_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int MIN_READ_LAT = 1;
  localparam int MAX_READ_LAT = 4;

  function automatic int be_width(input int word_size);
    return word_size / 8;
  endfunction

  function automatic bit word_size_ok(input int word_size);
    return (word_size >= 8) && ((word_size % 8) == 0);
  endfunction

  function automatic bit mem_size_ok(input int mem_size, input int addr_len);
    return (addr_len >= 1) && (addr_len < 31) && (mem_size >= 1) && (mem_size <= (1 << addr_len));
  endfunction

  function automatic bit read_lat_ok(input int read_lat);
    return (read_lat >= MIN_READ_LAT) && (read_lat <= MAX_READ_LAT);
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Valid/data/err delay line for read responses; DEPTH=0 degenerates to a pass-through.
module mem_rd_pipe #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_err,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_err
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst};
      assign o_valid  = i_valid;
      assign o_data   = i_data;
      assign o_err    = i_err;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             w_v_in;
        logic [WIDTH-1:0] w_d_in;
        logic             w_e_in;
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic             r_err;

        if (gi == 0) begin : g_head
          assign w_v_in = i_valid;
          assign w_d_in = i_data;
          assign w_e_in = i_err;
        end else begin : g_link
          assign w_v_in = g_stage[gi-1].r_valid;
          assign w_d_in = g_stage[gi-1].r_data;
          assign w_e_in = g_stage[gi-1].r_err;
        end

        // Data only advances with a valid beat so the output holds its last response.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
          end else begin
            r_valid <= w_v_in;
            r_err   <= w_v_in & w_e_in;
            if (w_v_in) begin
              r_data <= w_d_in;
            end
          end
        end
      end

      assign o_valid = g_stage[DEPTH-1].r_valid;
      assign o_data  = g_stage[DEPTH-1].r_data;
      assign o_err   = g_stage[DEPTH-1].r_err;
    end
  endgenerate

endmodule

// File: rtl/sync_mem_ctrl.sv
// Synchronous single-port memory with valid/ready requests, byte-enabled writes,
// configurable read latency and a post-reset zero-initialisation sweep.
module sync_mem_ctrl
  import mem_pkg::*;
#(
  parameter int  ADDR_LEN  = 8,
  parameter int  WORD_SIZE = 8,
  parameter int  MEM_SIZE  = 256,
  parameter int  READ_LAT  = 1,
  localparam int BE_W      = be_width(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_LEN-1:0]  req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  input  logic [BE_W-1:0]      req_be,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int               IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_LEN:0] LAST_IDX  = (ADDR_LEN + 1)'(MEM_SIZE - 1);
  localparam logic [ADDR_LEN:0] MEM_LIMIT = (ADDR_LEN + 1)'(MEM_SIZE);

  generate
    if (!word_size_ok(WORD_SIZE)) begin : g_bad_word_size
      $error("sync_mem_ctrl: WORD_SIZE must be a non-zero multiple of 8");
    end
    if (!mem_size_ok(MEM_SIZE, ADDR_LEN)) begin : g_bad_mem_size
      $error("sync_mem_ctrl: MEM_SIZE must lie in 1..2**ADDR_LEN");
    end
    if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
      $error("sync_mem_ctrl: READ_LAT out of range");
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_next;
  // One bit wider than the address so a full-size sweep ends without wrapping.
  logic [ADDR_LEN:0]   r_sweep_cnt;
  logic [ADDR_LEN:0]   w_sweep_next;
  logic                w_busy;
  logic                w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_cnt <= w_sweep_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sweep_next = r_sweep_cnt;
    w_busy       = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_busy = 1'b1;
        if (r_sweep_cnt == LAST_IDX) begin
          w_state_next = ST_READY;
        end else begin
          w_sweep_next = r_sweep_cnt + 1'b1;
        end
      end
      ST_READY: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  assign busy      = w_busy;
  assign req_ready = w_ready;

  logic             w_accept;
  logic             w_in_range;
  logic             w_rd_acc;
  logic [IDX_W-1:0] w_req_idx;

  assign w_accept   = req_valid & w_ready;
  assign w_in_range = ({1'b0, req_addr} < MEM_LIMIT);
  assign w_rd_acc   = w_accept & ~req_we;
  assign w_req_idx  = req_addr[IDX_W-1:0];

  // Single write port shared between the init sweep and accepted in-range writes.
  logic                 w_mem_we;
  logic [IDX_W-1:0]     w_mem_idx;
  logic [WORD_SIZE-1:0] w_mem_wdata;
  logic [BE_W-1:0]      w_mem_be;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = r_sweep_cnt[IDX_W-1:0];
    w_mem_wdata = '0;
    w_mem_be    = '1;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_mem_we = 1'b1;
      end else if (w_accept && req_we && w_in_range) begin
        w_mem_we    = 1'b1;
        w_mem_idx   = w_req_idx;
        w_mem_wdata = req_wdata;
        w_mem_be    = req_be;
      end
    end
  end

  logic [WORD_SIZE-1:0] r_mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_mem_be[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
        end
      end
    end
  end

  logic                 r_s0_valid;
  logic [WORD_SIZE-1:0] r_s0_data;
  logic                 r_s0_err;

  // First read stage samples the array at the accept edge; out-of-range reads yield zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_data  <= '0;
      r_s0_err   <= 1'b0;
    end else begin
      r_s0_valid <= w_rd_acc;
      r_s0_err   <= w_rd_acc & ~w_in_range;
      if (w_rd_acc) begin
        r_s0_data <= w_in_range ? r_mem[w_req_idx] : '0;
      end
    end
  end

  mem_rd_pipe #(
    .DEPTH (READ_LAT - 1),
    .WIDTH (WORD_SIZE)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_s0_valid),
    .i_data  (r_s0_data),
    .i_err   (r_s0_err),
    .o_valid (rsp_valid),
    .o_data  (rsp_data),
    .o_err   (rsp_err)
  );

endmodule

// File: tb/tb_sync_mem_ctrl.sv
// Directed bench: one default instance and one 16-bit / 200-word / latency-3 instance.
module tb_sync_mem_ctrl;

  logic clk;
  int   n_tests;
  int   n_fail;

  // Instance A: defaults (ADDR_LEN=8, WORD_SIZE=8, MEM_SIZE=256, READ_LAT=1)
  logic        a_rst, a_req_valid, a_req_ready, a_req_we;
  logic [7:0]  a_req_addr, a_req_wdata;
  logic [0:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_err, a_busy;
  logic [7:0]  a_rsp_data;

  // Instance B: WORD_SIZE=16, MEM_SIZE=200, READ_LAT=3
  logic        b_rst, b_req_valid, b_req_ready, b_req_we;
  logic [7:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic [1:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_err, b_busy;
  logic [15:0] b_rsp_data;

  sync_mem_ctrl u_a (
    .clk       (clk),
    .rst       (a_rst),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_we    (a_req_we),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_be    (a_req_be),
    .rsp_valid (a_rsp_valid),
    .rsp_data  (a_rsp_data),
    .rsp_err   (a_rsp_err),
    .busy      (a_busy)
  );

  sync_mem_ctrl #(
    .ADDR_LEN  (8),
    .WORD_SIZE (16),
    .MEM_SIZE  (200),
    .READ_LAT  (3)
  ) u_b (
    .clk       (clk),
    .rst       (b_rst),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_be    (b_req_be),
    .rsp_valid (b_rsp_valid),
    .rsp_data  (b_rsp_data),
    .rsp_err   (b_rsp_err),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input logic [7:0] addr, input logic [7:0] data, input logic [0:0] be);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = addr; a_req_wdata = data; a_req_be = be;
    step();
    a_req_valid = 1'b0; a_req_we = 1'b0;
  endtask

  task automatic a_read(input logic [7:0] addr);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = addr;
    step();
    a_req_valid = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] be);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = addr; b_req_wdata = data; b_req_be = be;
    step();
    b_req_valid = 1'b0; b_req_we = 1'b0;
  endtask

  task automatic b_read(input logic [7:0] addr);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = addr;
    step();
    b_req_valid = 1'b0;
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int pulses;
    logic        exp_v [6];
    logic [15:0] exp_d [6];

    n_tests = 0;
    n_fail  = 0;
    a_rst = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    step();
    step();

    chk("a_rst_busy",      a_busy,      1);
    chk("a_rst_ready",     a_req_ready, 0);
    chk("a_rst_rsp_valid", a_rsp_valid, 0);
    chk("a_rst_rsp_data",  a_rsp_data,  0);
    chk("a_rst_rsp_err",   a_rsp_err,   0);
    chk("b_rst_busy",      b_busy,      1);
    chk("b_rst_ready",     b_req_ready, 0);
    chk("b_rst_rsp_valid", b_rsp_valid, 0);

    // Sweep length: busy must last exactly MEM_SIZE cycles after rst drops.
    a_rst = 1'b0;
    b_rst = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 300; i++) begin
      if (a_busy) cnt_a++;
      if (b_busy) cnt_b++;
      step();
    end
    chk("a_sweep_cycles", cnt_a, 256);
    chk("b_sweep_cycles", cnt_b, 200);
    chk("a_ready_after",  a_req_ready, 1);
    chk("b_ready_after",  b_req_ready, 1);
    chk("a_busy_after",   a_busy, 0);

    // A: read of swept location, latency 1
    a_read(8'h10);
    chk("a_rd0_valid", a_rsp_valid, 1);
    chk("a_rd0_data",  a_rsp_data,  8'h00);
    chk("a_rd0_err",   a_rsp_err,   0);
    step();
    chk("a_rd0_pulse_end", a_rsp_valid, 0);

    // A: write then read-after-write next cycle
    a_write(8'h10, 8'hA5, 1'b1);
    chk("a_wr_no_rsp", a_rsp_valid, 0);
    a_read(8'h10);
    chk("a_raw_valid", a_rsp_valid, 1);
    chk("a_raw_data",  a_rsp_data,  8'hA5);
    step();
    chk("a_hold_valid", a_rsp_valid, 0);
    chk("a_hold_data",  a_rsp_data,  8'hA5);
    chk("a_hold_err",   a_rsp_err,   0);

    // A: be=0 write leaves word unchanged
    a_write(8'h10, 8'hFF, 1'b0);
    a_read(8'h10);
    chk("a_be0_data", a_rsp_data, 8'hA5);
    step();

    // B: byte-lane merge
    b_write(8'd5, 16'h1234, 2'b11);
    b_write(8'd5, 16'hFFFF, 2'b01);
    b_read(8'd5);
    chk("b_be_lat1", b_rsp_valid, 0);
    step();
    chk("b_be_lat2", b_rsp_valid, 0);
    step();
    chk("b_be_valid", b_rsp_valid, 1);
    chk("b_be_data",  b_rsp_data,  16'h12FF);
    chk("b_be_err",   b_rsp_err,   0);
    step();
    chk("b_be_pulse_end", b_rsp_valid, 0);

    // B: out-of-range read and dropped write
    b_read(8'd250);
    step();
    step();
    chk("b_oor_valid", b_rsp_valid, 1);
    chk("b_oor_data",  b_rsp_data,  16'h0000);
    chk("b_oor_err",   b_rsp_err,   1);
    step();
    chk("b_oor_err_clear", b_rsp_err, 0);
    b_write(8'd250, 16'h0077, 2'b11);
    b_read(8'd199);
    step();
    step();
    chk("b_last_valid", b_rsp_valid, 1);
    chk("b_last_data",  b_rsp_data,  16'h0000);
    chk("b_last_err",   b_rsp_err,   0);
    step();

    // B: back-to-back reads at latency 3
    b_write(8'd1, 16'h0011, 2'b11);
    b_write(8'd2, 16'h0022, 2'b11);
    b_write(8'd3, 16'h0033, 2'b11);
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{16'h0, 16'h0, 16'h0011, 16'h0022, 16'h0033, 16'h0};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'(i + 1);
      end else begin
        b_req_valid = 1'b0;
      end
      step();
      chk($sformatf("b_b2b_valid%0d", i), b_rsp_valid, exp_v[i]);
      if (exp_v[i]) chk($sformatf("b_b2b_data%0d", i), b_rsp_data, exp_d[i]);
    end

    // B: reset while a read is in flight
    b_write(8'd7, 16'h005A, 2'b11);
    b_read(8'd7);
    step();
    step();
    chk("b_pre_rst_data", b_rsp_data, 16'h005A);
    b_read(8'd7);
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    chk("b_flush_valid", b_rsp_valid, 0);
    cnt_b  = 0;
    pulses = 0;
    for (int i = 0; i < 250; i++) begin
      if (b_busy) cnt_b++;
      if (b_rsp_valid) pulses++;
      step();
    end
    chk("b_resweep_cycles", cnt_b, 200);
    chk("b_flush_pulses",   pulses, 0);
    b_read(8'd7);
    step();
    step();
    chk("b_post_rst_valid", b_rsp_valid, 1);
    chk("b_post_rst_data",  b_rsp_data,  16'h0000);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
